mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported synchronous memory.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed data-first priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              we,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                we_q, we_d;
  logic                i_gnt_q, i_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic                owner_d_q, owner_d_d;  // 1 = data port owns the transaction
  logic                pick_d;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_d = d_req;
`else
  logic last_d_q, last_d_d;  // 1 = data port was granted last
  assign pick_d = d_req && (!i_req || !last_d_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_d_q <= 1'b1;
    else       last_d_q <= last_d_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      address_q  <= '0;
      data_out_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      we_q       <= 1'b0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      owner_d_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      we_q       <= we_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      owner_d_q  <= owner_d_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    we_d       = 1'b0;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    owner_d_d  = owner_d_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d_d   = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d   = ISSUE;
          owner_d_d = pick_d;
`ifndef ARB_FIXED_PRIO_EN
          last_d_d  = pick_d;
`endif
          if (pick_d) begin
            address_d  = d_addr;
            data_out_d = d_wdata;
            we_d       = d_we;
            d_gnt_d    = 1'b1;
          end else begin
            address_d  = i_addr;
            i_gnt_d    = 1'b1;
          end
        end
      end
      // Memory samples address/we on this exit edge; we falls with it.
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (owner_d_q) begin
          d_rdata_d  = data_in;
          d_rvalid_d = 1'b1;
        end else begin
          i_rdata_d  = data_in;
          i_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign address  = address_q;
  assign data_out = data_out_q;
  assign we       = we_q;
  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule
